hdmi_timing_gen: RTL and testbench

// - Video timing generator / pixel output stage driving an external HDMI transmitter, e.g. ADV7513 in 24-bit RGB mode.
// - Publishes current pixel coordinate (x,y); upstream picture logic returns r,g,b combinationally in the same cycle.
// - Registers RGB with DE/HS/VS, all phase-aligned.
// - Sits at the leaf of the video path; clocked by the pixel clock (clk/2 of system, 25 MHz for 640x480@60).

---
 rtl/hdmi_timing_gen_if.sv | 25 ++
 rtl/hdmi_timing_gen.sv | 85 ++++++++
 tb/tb_hdmi_timing_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_gen_if.sv
// Pixel-fetch and HDMI transmitter pins of hdmi_timing_gen.
// master = timing generator side, slave = picture source / transmitter side.
interface hdmi_timing_gen_if;
  logic [11:0] x;
  logic [11:0] y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        hdmi_clk;
  logic [23:0] hdmi_d;
  logic        hdmi_de;
  logic        hdmi_hs;
  logic        hdmi_vs;
  logic        hdmi_int;

  modport master (
    output x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
    input  r, g, b, hdmi_int
  );

  modport slave (
    input  x, y, hdmi_clk, hdmi_d, hdmi_de, hdmi_hs, hdmi_vs,
    output r, g, b, hdmi_int
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Video timing generator and registered RGB/DE/HS/VS output stage for an HDMI transmitter.
// Define PIXEL_DOUBLE_EN to publish halved x/y coordinates (2x2 pixel doubling).
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  hdmi_timing_gen_if.master  vid
);

  localparam logic [11:0] HA       = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA       = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        active;
  logic        hs_on;
  logic        vs_on;
  logic        unused_int;

  assign unused_int = vid.hdmi_int;

  // v_cnt steps on the same edge that wraps h_cnt.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 12'd0;
      if (v_cnt == V_LAST) begin
        v_cnt <= 12'd0;
      end else begin
        v_cnt <= v_cnt + 12'd1;
      end
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign active = (h_cnt < HA) && (v_cnt < VA);
  assign hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef PIXEL_DOUBLE_EN
  assign vid.x = active ? {1'b0, h_cnt[11:1]} : 12'd0;
  assign vid.y = active ? {1'b0, v_cnt[11:1]} : 12'd0;
`else
  assign vid.x = active ? h_cnt : 12'd0;
  assign vid.y = active ? v_cnt : 12'd0;
`endif

  // RGB is captured with the sync terms of the same counter state, so all pins stay aligned.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vid.hdmi_d  <= 24'h0;
      vid.hdmi_de <= 1'b0;
      vid.hdmi_hs <= ~HS_POL;
      vid.hdmi_vs <= ~VS_POL;
    end else begin
      vid.hdmi_d  <= active ? {vid.r, vid.g, vid.b} : 24'h0;
      vid.hdmi_de <= active;
      vid.hdmi_hs <= hs_on ? HS_POL : ~HS_POL;
      vid.hdmi_vs <= vs_on ? VS_POL : ~VS_POL;
    end
  end

  // Inverted clock puts the transmitter's rising edge mid-way through each data cycle.
  assign vid.hdmi_clk = ~clk;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench for hdmi_timing_gen: a full-size 640x480 instance and a shrunken
// instance (so whole frames fit a short run), both checked against a position-based model.
module tb_hdmi_timing_gen;

  localparam int SHA = 16, SHF = 2, SHS = 4, SHT = 25;
  localparam int SVA = 6,  SVF = 2, SVS = 2, SVT = 13;

  typedef struct {
    bit active;
    bit hsOn;
    bit vsOn;
    int x;
    int y;
  } pix_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] rk = 8'h00;
  logic [7:0] gk = 8'h00;
  logic [7:0] bk = 8'hA5;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  bit lastRst = 1'b1;
  bit logEn = 1'b0;
  bit bigDe[$];
  bit bigHs[$];
  bit smallDe[$];
  bit smallVs[$];

  hdmi_timing_gen_if bigIf ();
  hdmi_timing_gen_if smallIf ();

  assign bigIf.r = bigIf.x[7:0] ^ rk;
  assign bigIf.g = bigIf.y[7:0] ^ gk;
  assign bigIf.b = bk;
  assign bigIf.hdmi_int = 1'b0;
  assign smallIf.r = smallIf.x[7:0] ^ rk;
  assign smallIf.g = smallIf.y[7:0] ^ gk;
  assign smallIf.b = bk;
  assign smallIf.hdmi_int = 1'b0;

  hdmi_timing_gen bigDut (
    .clk    (clk),
    .resetn (resetn),
    .vid    (bigIf.master)
  );

  hdmi_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHT - SHA - SHF - SHS),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVT - SVA - SVF - SVS),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) smallDut (
    .clk    (clk),
    .resetn (resetn),
    .vid    (smallIf.master)
  );

  always #5 clk = ~clk;

  // Model: the pixel presented on x/y is simply position p counted from reset release.
  function automatic pix_t pixelAt(input int p, input int ha, hfp, hsw, ht, va, vfp, vsw, vt);
    pix_t res;
    int h;
    int v;
    h = p % ht;
    v = (p / ht) % vt;
    res.active = (h < ha) && (v < va);
    res.hsOn = (h >= ha + hfp) && (h < ha + hfp + hsw);
    res.vsOn = (v >= va + vfp) && (v < va + vfp + vsw);
`ifdef PIXEL_DOUBLE_EN
    res.x = res.active ? h / 2 : 0;
    res.y = res.active ? v / 2 : 0;
`else
    res.x = res.active ? h : 0;
    res.y = res.active ? v : 0;
`endif
    return res;
  endfunction

  function automatic int findEdge(input bit q[$], input int from, input bit level);
    for (int i = from; i < q.size(); i++) begin
      if (q[i] == level && (i == 0 || q[i-1] != level)) return i;
    end
    return -1;
  endfunction

  function automatic int runLen(input bit q[$], input int from, input bit level);
    int len = 0;
    if (from < 0) return -1;
    for (int i = from; i < q.size() && q[i] == level; i++) len++;
    return len;
  endfunction

  function automatic int countRises(input bit q[$], input int from, input int upto);
    int cnt = 0;
    for (int i = from; i < upto && i < q.size(); i++) begin
      if (q[i] && (i == 0 || !q[i-1])) cnt++;
    end
    return cnt;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkInst(input string tag, input logic [11:0] ox, oy, input logic [23:0] od,
                           input logic ode, ohs, ovs, olck,
                           input int ha, hfp, hsw, ht, va, vfp, vsw, vt, input bit hp, vp);
    pix_t cur;
    pix_t prev;
    logic [23:0] ed;
    logic ede, ehs, evs;
    cur = pixelAt(n, ha, hfp, hsw, ht, va, vfp, vsw, vt);
    if (lastRst) begin
      ed = 24'h0; ede = 1'b0; ehs = ~hp; evs = ~vp;
    end else begin
      prev = pixelAt(n - 1, ha, hfp, hsw, ht, va, vfp, vsw, vt);
      ede = prev.active;
      ehs = prev.hsOn ? hp : ~hp;
      evs = prev.vsOn ? vp : ~vp;
      ed = prev.active ? {8'(prev.x) ^ rk, 8'(prev.y) ^ gk, bk} : 24'h0;
    end
    checkEq({tag, "_x"}, 32'(ox), 32'(cur.x));
    checkEq({tag, "_y"}, 32'(oy), 32'(cur.y));
    checkEq({tag, "_d"}, 32'(od), 32'(ed));
    checkEq({tag, "_de"}, 32'(ode), 32'(ede));
    checkEq({tag, "_hs"}, 32'(ohs), 32'(ehs));
    checkEq({tag, "_vs"}, 32'(ovs), 32'(evs));
    checkEq({tag, "_hdmiclk"}, 32'(olck), 32'(1));
  endtask

  task automatic checkOutput();
    checkInst("big", bigIf.x, bigIf.y, bigIf.hdmi_d, bigIf.hdmi_de, bigIf.hdmi_hs,
              bigIf.hdmi_vs, bigIf.hdmi_clk, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0, 1'b0);
    checkInst("small", smallIf.x, smallIf.y, smallIf.hdmi_d, smallIf.hdmi_de, smallIf.hdmi_hs,
              smallIf.hdmi_vs, smallIf.hdmi_clk, SHA, SHF, SHS, SHT, SVA, SVF, SVS, SVT,
              1'b1, 1'b0);
  endtask

  // One clock per iteration: drive resetn, advance the model at posedge, check at negedge.
  task automatic applyStimulus(input bit rn, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      resetn = rn;
      @(posedge clk);
      if (!resetn) begin
        n = 0;
        lastRst = 1'b1;
      end else begin
        n++;
        lastRst = 1'b0;
      end
      #1;
      checkEq("hdmiclk_low", 32'(bigIf.hdmi_clk), 32'(0));
      @(negedge clk);
      checkOutput();
      if (logEn && !lastRst) begin
        bigDe.push_back(bigIf.hdmi_de);
        bigHs.push_back(bigIf.hdmi_hs);
        smallDe.push_back(smallIf.hdmi_de);
        smallVs.push_back(smallIf.hdmi_vs);
      end
    end
  endtask

  task automatic releaseAndCheckStart();
    resetn = 1'b1;
    #1;
    checkEq("rel_x", 32'(bigIf.x), 32'(0));
    checkEq("rel_y", 32'(bigIf.y), 32'(0));
    applyStimulus(1'b1, 1);
    checkEq("first_de", 32'(bigIf.hdmi_de), 32'(1));
    checkEq("first_d", 32'(bigIf.hdmi_d), 32'({rk, gk, bk}));
    checkEq("first_de_small", 32'(smallIf.hdmi_de), 32'(1));
  endtask

  initial begin
    int iR, iF, iR2, sR, sF, sR2;
    logic [7:0] lastR;
`ifdef PIXEL_DOUBLE_EN
    lastR = 8'h3F;
`else
    lastR = 8'h7F;
`endif

    applyStimulus(1'b0, 3);
    checkEq("rst_de", 32'(bigIf.hdmi_de), 32'(0));
    checkEq("rst_hs", 32'(bigIf.hdmi_hs), 32'(1));
    checkEq("rst_vs", 32'(bigIf.hdmi_vs), 32'(1));
    checkEq("rst_d", 32'(bigIf.hdmi_d), 32'(0));

    logEn = 1'b1;
    bigDe.push_back(1'b0);
    bigHs.push_back(1'b1);
    smallDe.push_back(1'b0);
    smallVs.push_back(1'b1);
    releaseAndCheckStart();
    applyStimulus(1'b1, 639);
    checkEq("last_px_d", 32'(bigIf.hdmi_d), 32'({lastR, 8'h00, 8'hA5}));
    checkEq("last_px_de", 32'(bigIf.hdmi_de), 32'(1));
    applyStimulus(1'b1, 1);
    checkEq("after_px_de", 32'(bigIf.hdmi_de), 32'(0));
    checkEq("after_px_d", 32'(bigIf.hdmi_d), 32'(0));
    applyStimulus(1'b1, 1200);
    logEn = 1'b0;

    // Index 0 of each log is the reset-state sample, so edges land one past the pixel index.
    iR  = findEdge(bigDe, 0, 1'b1);
    iF  = findEdge(bigHs, 0, 1'b0);
    iR2 = findEdge(bigDe, iR + 1, 1'b1);
    checkEq("line_de_len", 32'(runLen(bigDe, iR, 1'b1)), 32'(640));
    checkEq("line_hs_len", 32'(runLen(bigHs, iF, 1'b0)), 32'(96));
    checkEq("line_hs_ofs", 32'(iF - iR), 32'(656));
    checkEq("line_period", 32'(iR2 - iR), 32'(800));

    sR  = findEdge(smallDe, 0, 1'b1);
    sF  = findEdge(smallVs, 0, 1'b0);
    sR2 = findEdge(smallDe, sR + SHT * SVT - 1, 1'b1);
    checkEq("frame_vs_len", 32'(runLen(smallVs, sF, 1'b0)), 32'(SVS * SHT));
    checkEq("frame_vs_ofs", 32'(sF - sR), 32'((SVA + SVF) * SHT));
    checkEq("frame_lines", 32'(countRises(smallDe, sR, sR + SHT * SVT)), 32'(SVA));
    checkEq("frame_period", 32'(sR2 - sR), 32'(SHT * SVT));

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, $urandom_range(50, 900));
      rk = 8'($urandom);
      gk = 8'($urandom);
      bk = 8'($urandom);
      applyStimulus(1'b0, 1);
      releaseAndCheckStart();
    end

    applyStimulus(1'b1, 1099);
    checkEq("mid_x", 32'(bigIf.x), 32'(300));
    checkEq("mid_y", 32'(bigIf.y), 32'(1));
    applyStimulus(1'b0, 1);
    checkEq("mid_rst_de", 32'(bigIf.hdmi_de), 32'(0));
    checkEq("mid_rst_hs", 32'(bigIf.hdmi_hs), 32'(1));
    checkEq("mid_rst_vs", 32'(bigIf.hdmi_vs), 32'(1));
    checkEq("mid_rst_d", 32'(bigIf.hdmi_d), 32'(0));
    releaseAndCheckStart();
    applyStimulus(1'b1, 700);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
